// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared feedback-loop types, constants and saturating helpers
package fb_pkg;

  // Encoder pulse FSM encoding, shared with the step and speed controllers.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pulse_state_e;

  localparam logic [23:0] THRESH_DEFAULT = 24'd1048576;
  localparam logic [15:0] VMAX_DEFAULT   = 16'd4000;
  localparam logic [15:0] DEG_PER_TICK   = 16'd1;

  // Add in 17 bits, then clamp to lim, so the sum can never wrap.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] lim);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[15:0];
  endfunction

  // Subtract in 17 bits; a borrow means the result would go negative, so floor at 0.
  function automatic logic [15:0] floor_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[16] ? 16'd0 : d[15:0];
  endfunction

endpackage

// File: rtl/motor_encoder_emu_if.sv
// rtl/motor_encoder_emu_if.sv - controller-facing drive inputs and encoder/monitor outputs
interface motor_encoder_emu_if;
  logic        pwm;
  logic        motor_en;
  logic        encoder;
  logic [15:0] tick_count;
  logic [15:0] speed;
  logic        overrun;

  // Controller side: drives the motor, reads back the encoder and debug counters.
  modport master (
    output pwm,
    output motor_en,
    input  encoder,
    input  tick_count,
    input  speed,
    input  overrun
  );

  // Plant side: the emulator itself.
  modport slave (
    input  pwm,
    input  motor_en,
    output encoder,
    output tick_count,
    output speed,
    output overrun
  );
endinterface

// File: rtl/pulse_shaper.sv
// rtl/pulse_shaper.sv - turns single-cycle ticks into fixed-width encoder pulses with a pending queue
module pulse_shaper
  import fb_pkg::*;
#(
  parameter logic [15:0] PULSE_W  = 16'd50,
  parameter logic [3:0]  PEND_MAX = 4'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic encoder,
  output logic overrun
);

  pulse_state_e state_q, state_d;
  logic [15:0]  timer_q, timer_d;
  logic [3:0]   pending_q, pending_d;
  logic         encoder_q, encoder_d;
  logic         overrun_q, overrun_d;
  logic         enter_high;
  logic         want_pulse;

  // A fresh tick counts as work even before it reaches the queue, so an idle
  // shaper fires on the very next cycle.
  assign want_pulse = (pending_q != 4'd0) | tick;

  // Pulse FSM: HIGH and LOW each last exactly PULSE_W cycles (timer counts W-1..0).
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    encoder_d  = encoder_q;
    enter_high = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (want_pulse) begin
          state_d    = ST_HIGH;
          timer_d    = PULSE_W - 16'd1;
          encoder_d  = 1'b1;
          enter_high = 1'b1;
        end
      end
      ST_HIGH: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else begin
          state_d   = ST_LOW;
          timer_d   = PULSE_W - 16'd1;
          encoder_d = 1'b0;
        end
      end
      ST_LOW: begin
        if (timer_q != 16'd0) begin
          timer_d = timer_q - 16'd1;
        end else if (want_pulse) begin
          state_d    = ST_HIGH;
          timer_d    = PULSE_W - 16'd1;
          encoder_d  = 1'b1;
          enter_high = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        timer_d   = 16'd0;
        encoder_d = 1'b0;
      end
    endcase
  end

  // Pending queue: a tick and a pulse start in the same cycle cancel out; a tick
  // that finds the queue full is lost and latches overrun.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (tick && !enter_high) begin
      if (pending_q == PEND_MAX) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = pending_q + 4'd1;
      end
    end else if (!tick && enter_high) begin
      pending_d = pending_q - 4'd1;
    end
  end

  // State registers; async reset drops the encoder immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= 16'd0;
      pending_q <= 4'd0;
      encoder_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      encoder_q <= encoder_d;
      overrun_q <= overrun_d;
    end
  end

  assign encoder = encoder_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/motor_encoder_emu.sv
// rtl/motor_encoder_emu.sv - first-order motor plant with one-pulse-per-degree encoder output
module motor_encoder_emu
  import fb_pkg::*;
#(
  parameter logic [15:0] ACCEL    = 16'd4,
  parameter logic [15:0] DECEL    = 16'd2,
  parameter logic [15:0] VMAX     = VMAX_DEFAULT,
  parameter logic [23:0] THRESH   = THRESH_DEFAULT,
  parameter logic [15:0] PULSE_W  = 16'd50,
  parameter logic [3:0]  PEND_MAX = 4'd15
) (
  input logic               clk,
  input logic               rst_n,
  motor_encoder_emu_if.slave bus
);

  logic [15:0] speed_q, speed_d;
  logic [23:0] acc_q, acc_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic [24:0] sum;
  logic        tick;
  logic        drive;
  logic        encoder;
  logic        overrun;

  // pwm is taken raw: the controller owns any glitch filtering.
  assign drive = bus.motor_en & bus.pwm;

  // Velocity: ramp up while driven, coast down otherwise, clamped at both ends.
  always_comb begin
    speed_d = drive ? sat_add(speed_q, ACCEL, VMAX) : floor_sub(speed_q, DECEL);
  end

  // Position: integrate speed; each THRESH crossing is one degree. VMAX < THRESH
  // keeps it to at most one crossing per cycle. acc is kept while coasting.
  always_comb begin
    sum          = {1'b0, acc_q} + {9'd0, speed_q};
    tick         = (sum >= {1'b0, THRESH});
    acc_d        = tick ? (sum[23:0] - THRESH) : sum[23:0];
    tick_count_d = tick_count_q + {15'd0, tick};
  end

  // Plant state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q      <= 16'd0;
      acc_q        <= 24'd0;
      tick_count_q <= 16'd0;
    end else begin
      speed_q      <= speed_d;
      acc_q        <= acc_d;
      tick_count_q <= tick_count_d;
    end
  end

  pulse_shaper #(
    .PULSE_W (PULSE_W),
    .PEND_MAX(PEND_MAX)
  ) u_pulse_shaper (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .encoder(encoder),
    .overrun(overrun)
  );

  assign bus.encoder    = encoder;
  assign bus.overrun    = overrun;
  assign bus.speed      = speed_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_motor_encoder_emu.sv
// tb/tb_motor_encoder_emu.sv - bench for motor_encoder_emu: vector table plus multi-cycle sequences
module tb_motor_encoder_emu;

  logic clk;
  logic rst_n0;
  logic rst_n1;

  motor_encoder_emu_if if0();
  motor_encoder_emu_if if1();

  motor_encoder_emu u_dut (
    .clk  (clk),
    .rst_n(rst_n0),
    .bus  (if0)
  );

  motor_encoder_emu #(.PULSE_W(16'd200)) u_ovr (
    .clk  (clk),
    .rst_n(rst_n1),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference plant for u_dut: default ACCEL=4, DECEL=2, VMAX=4000, THRESH=2^20.
  int m_speed = 0;
  int m_acc   = 0;
  int m_tc    = 0;

  always @(posedge clk or negedge rst_n0) begin
    if (!rst_n0) begin
      m_speed <= 0;
      m_acc   <= 0;
      m_tc    <= 0;
    end else begin
      m_acc   <= (m_acc + m_speed >= 1048576) ? (m_acc + m_speed - 1048576) : (m_acc + m_speed);
      m_tc    <= (m_acc + m_speed >= 1048576) ? ((m_tc + 1) % 65536) : m_tc;
      m_speed <= (if0.motor_en && if0.pwm) ? ((m_speed + 4 > 4000) ? 4000 : m_speed + 4)
                                           : ((m_speed < 2) ? 0 : m_speed - 2);
    end
  end

  // Observation state, updated only from tick_clk.
  int   cyc = 0;
  logic enc0_prev = 1'b0;
  logic rose0 = 1'b0;
  logic fell0 = 1'b0;
  int   rises0 = 0;
  logic enc1_prev = 1'b0;
  logic rose1 = 1'b0;
  logic fell1 = 1'b0;
  logic tick1 = 1'b0;
  logic [15:0] tc1_prev = 16'd0;
  int   p1 = 0;
  logic exp_ovr1 = 1'b0;
  logic ovr_event = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT event", name);
  endtask

  // One clock: sample at the falling edge and track edges, ticks and the
  // pending-queue occupancy of u_ovr as seen from its outputs.
  task automatic tick_clk();
    @(negedge clk);
    cyc++;
    rose0 = if0.encoder && !enc0_prev;
    fell0 = !if0.encoder && enc0_prev;
    if (!rst_n0) rises0 = 0;
    else if (rose0) rises0++;
    enc0_prev = if0.encoder;

    rose1 = if1.encoder && !enc1_prev;
    fell1 = !if1.encoder && enc1_prev;
    tick1 = (if1.tick_count != tc1_prev);
    ovr_event = 1'b0;
    if (!rst_n1) begin
      p1 = 0;
      exp_ovr1 = 1'b0;
    end else if (tick1 && !rose1) begin
      if (p1 == 15) begin
        if (!exp_ovr1) ovr_event = 1'b1;
        exp_ovr1 = 1'b1;
      end else begin
        p1++;
      end
    end else if (!tick1 && rose1) begin
      p1--;
    end
    enc1_prev = if1.encoder;
    tc1_prev  = if1.tick_count;
  endtask

  task automatic wait_rise0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick_clk();
      if (rose0) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_fall0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick_clk();
      if (fell0) begin
        at = cyc;
        break;
      end
    end
  endtask

  typedef struct {
    logic rst;
    logic pwm;
    logic en;
    int   ncyc;
    int   speed;
    int   tc;
    logic enc;
    logic ovr;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int t0, t1, tm, r, f, rprev, tc_hold, tc_base, r1c;
    logic stop, w_checked, ovr1_prev, got;

    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    if0.pwm = 1'b1;
    if0.motor_en = 1'b1;
    if1.pwm = 1'b1;
    if1.motor_en = 1'b1;

    // rst, pwm, en, cycles, speed, tick_count, encoder, overrun
    vecs[0] = '{1'b0, 1'b1, 1'b1, 10,  0, 0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1,  1,  4, 0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1,  9, 40, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0,  3, 34, 0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1,  2, 30, 0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1,  5, 50, 0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 25,  0, 0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b0,  3,  0, 0, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      rst_n0 = vecs[v].rst;
      if0.pwm = vecs[v].pwm;
      if0.motor_en = vecs[v].en;
      repeat (vecs[v].ncyc) tick_clk();
      check($sformatf("vec%0d speed", v), int'(if0.speed), vecs[v].speed);
      check($sformatf("vec%0d tick_count", v), int'(if0.tick_count), vecs[v].tc);
      check($sformatf("vec%0d encoder", v), int'(if0.encoder), int'(vecs[v].enc));
      check($sformatf("vec%0d overrun", v), int'(if0.overrun), int'(vecs[v].ovr));
    end

    // Ramp from standstill: 4000 exactly at cycle 1000, first tick latency one cycle.
    if0.pwm = 1'b1;
    if0.motor_en = 1'b1;
    t0 = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick_clk();
      if (i == 999)  check("ramp speed @999", int'(if0.speed), 3996);
      if (i == 1000) check("ramp speed @1000", int'(if0.speed), 4000);
      if (t0 < 0 && if0.tick_count != 16'd0) begin
        t0 = i;
        check("first tick encoder rise", int'(rose0), 1);
      end
    end
    if (t0 < 0) fail_timeout("ramp first tick");
    check("cruise speed held", int'(if0.speed), 4000);
    check("cruise speed model", int'(if0.speed), m_speed);

    rprev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_rise0(400, r);
      if (r < 0) begin
        fail_timeout("cruise rise");
        break;
      end
      check("tick_count vs rises", int'(if0.tick_count), rises0);
      check("tick_count vs model", int'(if0.tick_count), m_tc);
      if (rprev >= 0) check_range("cruise pulse spacing", r - rprev, 262, 263);
      rprev = r;
      wait_fall0(100, f);
      if (f < 0) begin
        fail_timeout("cruise fall");
        break;
      end
      check("cruise pulse width", f - r, 50);
    end
    check("no overrun at cruise", int'(if0.overrun), 0);

    // Coast: 2/clk down to zero in 2000 clk, then ticks stop.
    if0.motor_en = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      tick_clk();
      if (i == 1999) check("coast speed @1999", int'(if0.speed), 2);
    end
    check("coast speed @2000", int'(if0.speed), 0);
    tc_hold = int'(if0.tick_count);
    repeat (600) tick_clk();
    check("ticks stopped", int'(if0.tick_count), tc_hold);
    check("encoder idle after coast", int'(if0.encoder), 0);
    check("coast tick_count model", int'(if0.tick_count), m_tc);

    // Re-enable: retained acc gives an earlier first tick than from zero.
    if0.motor_en = 1'b1;
    tc_base = int'(if0.tick_count);
    t1 = -1;
    tm = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick_clk();
      if (t1 < 0 && int'(if0.tick_count) != tc_base) t1 = i;
      if (tm < 0 && m_tc != tc_base) tm = i;
      if (t1 >= 0 && tm >= 0) break;
    end
    if (t1 < 0) fail_timeout("re-enable first tick");
    else begin
      check("re-enable tick timing vs model", t1, tm);
      check_range("re-enable tick earlier than from zero", t1, 1, t0 - 1);
    end

    // Async reset 20 clocks into a HIGH pulse clears outputs before the next edge.
    repeat (19) tick_clk();
    check("mid-pulse encoder high", int'(if0.encoder), 1);
    #2;
    rst_n0 = 1'b0;
    #1;
    check("async reset encoder", int'(if0.encoder), 0);
    check("async reset speed", int'(if0.speed), 0);
    check("async reset tick_count", int'(if0.tick_count), 0);
    check("async reset overrun", int'(if0.overrun), 0);
    repeat (3) tick_clk();
    check("held reset encoder", int'(if0.encoder), 0);
    rst_n0 = 1'b1;

    // Closed loop: a step controller wanting 10 degrees stops after 10 edges.
    if0.pwm = 1'b1;
    if0.motor_en = 1'b1;
    stop = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      tick_clk();
      if (rises0 == 10 / int'(fb_pkg::DEG_PER_TICK)) begin
        if0.motor_en = 1'b0;
        if0.pwm = 1'b0;
        stop = 1'b1;
        break;
      end
    end
    if (!stop) fail_timeout("closed loop 10 edges");
    check("closed loop ticks at stop", int'(if0.tick_count), 10);
    repeat (2500) tick_clk();
    check("closed loop speed decays", int'(if0.speed), 0);
    check("closed loop tick_count model", int'(if0.tick_count), m_tc);
    check("closed loop encoder idle", int'(if0.encoder), 0);
    tc_hold = int'(if0.tick_count);
    repeat (300) tick_clk();
    check("closed loop no further ticks", int'(if0.tick_count), tc_hold);

    // Overrun: 200-clk pulses cannot keep up with ~262-clk ticks.
    rst_n1 = 1'b1;
    w_checked = 1'b0;
    ovr1_prev = 1'b0;
    got = 1'b0;
    r1c = 0;
    for (int i = 0; i < 22000; i++) begin
      tick_clk();
      if (rose1) r1c = cyc;
      if (fell1 && !w_checked) begin
        check("overrun inst pulse width", cyc - r1c, 200);
        w_checked = 1'b1;
      end
      if (ovr_event) begin
        check("overrun set on dropped tick", int'(if1.overrun), 1);
        check("overrun clear before drop", int'(ovr1_prev), 0);
        got = 1'b1;
        break;
      end
      ovr1_prev = if1.overrun;
    end
    if (!got) fail_timeout("overrun");
    tc_base = int'(if1.tick_count);
    repeat (1000) tick_clk();
    check_range("tick_count continues during overrun", int'(if1.tick_count) - tc_base, 3, 4);
    check("overrun sticky", int'(if1.overrun), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_encoder_emu.md
Name: motor_encoder_emu

Overview:
Synthesizable motor-plus-encoder plant model for hardware-in-the-loop bring-up of the feedback controllers without a physical motor.
- Consumes the PWM and motor_en outputs of a step or speed controller.
- Integrates a first-order velocity model and emits single-channel encoder pulses, one per degree, that feed back into the controller's encoder input.
- Also exposes tick_count, speed and overrun for on-board monitoring and debug.

Parameters:
ACCEL, 16'd4, velocity increment per clk while pwm=1 and motor_en=1
DECEL, 16'd2, velocity decrement per clk otherwise
VMAX, 16'd4000, velocity saturation limit; must be < THRESH
THRESH, 24'd1048576, accumulator units per encoder tick (one degree)
PULSE_W, 16'd50, clocks high per encoder pulse; also minimum low gap
PEND_MAX, 4'd15, pending-tick queue depth

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pwm  in  1  PWM drive from controller, same clock domain, no synchronizer
motor_en  in  1  driver enable; 0 means coast
encoder  out  1  emulated encoder pulse train, registered
tick_count  out  16  total ticks generated, wraps at 65535->0
speed  out  16  current velocity register
overrun  out  1  sticky; set when a tick is lost

Behaviour:
Reset (async, rst_n=0):
- Outputs: encoder=0, tick_count=0, speed=0, overrun=0.
- Internal: acc=0, pending=0, timer=0, state=IDLE.
- Takes effect immediately, including mid-pulse.

Velocity, per clk:
- If motor_en & pwm: speed <= min(speed+ACCEL, VMAX).
- Else: speed <= max(speed-DECEL, 0).
- Arithmetic is done 17-bit before clamping, so there is no wrap.

Position (24-bit acc), per clk:
- sum = acc + speed, computed 25-bit.
- If sum >= THRESH: acc <= sum - THRESH and tick=1 this cycle. Otherwise acc <= sum.
- VMAX < THRESH guarantees at most one tick per clk.
- acc is retained when the motor stops. There is no reset of acc on motor_en=0.
- On each tick, tick_count <= tick_count+1.

Pending queue (4-bit):
- A tick increments pending; entering HIGH decrements it.
- Both in the same cycle: pending unchanged.
- Tick while pending==PEND_MAX and not entering HIGH: tick dropped from the queue, overrun <= 1 until reset. tick_count still increments.

Pulse FSM (states IDLE, HIGH, LOW; timer 16-bit):
- IDLE:
  - If pending>0 or tick: go to HIGH, timer <= PULSE_W-1, encoder <= 1.
  - A tick in IDLE with pending==0 goes straight to HIGH without queueing.
- HIGH:
  - timer!=0: timer decrements.
  - timer==0: go to LOW, timer <= PULSE_W-1, encoder <= 0.
- LOW:
  - timer!=0: timer decrements.
  - timer==0: if pending>0 or tick, go to HIGH (reload, encoder <= 1); else go to IDLE.

Timing and boundaries:
- Latency: a tick in cycle t gives encoder=1 from cycle t+1 when the FSM is idle.
- Each pulse is exactly PULSE_W clocks high, followed by at least PULSE_W clocks low.
- PULSE_W=1 is legal: 1 high, 1 low.
- motor_en deasserted mid-pulse: the current pulse and queued pulses still complete, because the plant coasts.
- Input pwm is used raw. Glitch filtering is the controller's responsibility.

Decomposition:
- Shared package `fb_pkg`: FSM state encodings (2-bit IDLE/HIGH/LOW), default THRESH and VMAX constants, and a degrees-per-tick constant shared with the step and speed controllers.
- One natural sub-module: `pulse_shaper`, containing the pending queue, pulse FSM and timer. Inputs: tick. Outputs: encoder, overrun.
- The velocity and accumulator logic stays in the top level.

Test Plan:
1. Reset: hold rst_n=0 with pwm=1 and motor_en=1 for 10 clk -> encoder, speed, tick_count and overrun all stay 0. Release -> speed=4 one clk later.
2. Ramp: pwm=1, motor_en=1 constant -> speed reaches 4000 at clk 1000 and holds. Once saturated, encoder pulses are spaced 262 or 263 clk, 50 clk high each. tick_count equals the rising-edge count.
3. Coast: after cruise, motor_en=0 -> speed falls 2/clk to 0 in 2000 clk, ticks stop, acc is held. Re-enable -> the first tick arrives earlier than from acc=0.
4. Overrun: PULSE_W=200, VMAX=4000 -> one tick per ~262 clk against a 400-clk pulse cycle. pending climbs and overrun asserts on the tick after pending=15. tick_count keeps counting.
5. Async reset mid-pulse: assert rst_n=0 at clk 20 of HIGH -> encoder=0 within the same cycle, not waiting for a clk edge. All state clears.
6. Closed loop with the step controller: ndegs=10, enable pulsed -> the controller sees 10 encoder rising edges, then drops motor_en. speed then decays to 0, and the bench checks there are no further controller-enabled cycles.
